// File: rtl/instr_encoder.sv
// instr_encoder: packs field-level RV32I descriptors into instruction words and
// streams them, with sequential word addresses, toward an instruction-memory
// loader. Illegal descriptors are consumed, reported and counted, but emit nothing.
module instr_encoder #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_last,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_funct3,
   input  logic [6:0]           in_funct7,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic [ADDR_W-1:0]    out_addr,
   output logic                 out_last,
   output logic                 busy,
   output logic                 done,
   output logic                 err_pulse,
   output logic [2:0]           err_code,
   output logic [ERR_CNT_W-1:0] err_count
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
   typedef enum logic [2:0] {T_BAD, T_I, T_S, T_B, T_U, T_J, T_R} itype_t;
   typedef enum logic [2:0] {
      E_NONE     = 3'd0,
      E_OPCODE   = 3'd1,
      E_MISALIGN = 3'd2,
      E_RANGE    = 3'd3,
      E_ULOW     = 3'd4
   } err_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;

   itype_t      w_type;
   err_t        w_code;
   logic [31:0] w_word;
   logic        w_accept;
   logic        w_i_fits;
   logic        w_b_fits;
   logic        w_j_fits;

   assign in_ready = (r_state == S_RUN) && (!out_valid || out_ready);
   assign w_accept = in_valid && in_ready;

   // Sign-extension checks: the bits above the encodable field must all match.
   assign w_i_fits = (&in_imm[31:11]) || !(|in_imm[31:11]);
   assign w_b_fits = (&in_imm[31:12]) || !(|in_imm[31:12]);
   assign w_j_fits = (&in_imm[31:20]) || !(|in_imm[31:20]);

   // Classify the opcode into an instruction format.
   always_comb begin
      w_type = T_BAD;
      case (in_opcode)
         7'b0010011, 7'b0000011, 7'b1110011, 7'b1100111: w_type = T_I;
         7'b0100011:                                     w_type = T_S;
         7'b1100011:                                     w_type = T_B;
         7'b0110111, 7'b0010111:                         w_type = T_U;
         7'b1101111:                                     w_type = T_J;
         7'b0110011:                                     w_type = T_R;
         default:                                        w_type = T_BAD;
      endcase
   end

   // Assemble the word for the format and pick the highest-priority reject reason.
   always_comb begin
      w_word = '0;
      w_code = E_NONE;
      case (w_type)
         T_I: begin
            w_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
            if (!w_i_fits) w_code = E_RANGE;
         end
         T_S: begin
            w_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
            if (!w_i_fits) w_code = E_RANGE;
         end
         T_B: begin
            w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                      in_imm[4:1], in_imm[11], in_opcode};
            if (in_imm[0])      w_code = E_MISALIGN;
            else if (!w_b_fits) w_code = E_RANGE;
         end
         T_U: begin
            w_word = {in_imm[31:12], in_rd, in_opcode};
            if (|in_imm[11:0]) w_code = E_ULOW;
         end
         T_J: begin
            w_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            if (in_imm[0])      w_code = E_MISALIGN;
            else if (!w_j_fits) w_code = E_RANGE;
         end
         T_R: begin
            w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         end
         default: begin
            w_code = E_OPCODE;
         end
      endcase
   end

   // Run sequencing, output register, addressing and error bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_addr    <= ADDR_W'(BASE_ADDR);
         out_valid <= 1'b0;
         out_instr <= '0;
         out_addr  <= '0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err_pulse <= 1'b0;
         err_code  <= '0;
         err_count <= '0;
      end else begin
         err_pulse <= 1'b0;
         done      <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_RUN;
                  busy      <= 1'b1;
                  r_addr    <= ADDR_W'(BASE_ADDR);
                  err_code  <= '0;
                  err_count <= '0;
               end
            end
            S_RUN: begin
               if (w_accept) begin
                  if (w_code == E_NONE) begin
                     out_valid <= 1'b1;
                     out_instr <= w_word;
                     out_addr  <= r_addr;
                     out_last  <= in_last;
                     r_addr    <= r_addr + 1'b1;
                  end else begin
                     err_pulse <= 1'b1;
                     if (err_code == 3'd0) err_code <= w_code;
                     if (err_count != '1) err_count <= err_count + 1'b1;
                  end
                  if (in_last) r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!out_valid || out_ready) begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
